// File: rtl/sm_window_accumulator.sv
// Sums NUM_TERMS sign-magnitude products into one saturated sign-magnitude
// window result held in a single-entry valid/ready output register.
//
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   product_in  sign-magnitude product (bit DATA_WIDTH-1 = sign)
//   in_valid    product_in valid;  in_ready  product accepted this cycle
//   sum_out     sign-magnitude window result
//   out_valid   sum_out unconsumed; out_ready downstream consumes sum_out
//   term_idx    index of the next term to be accepted
//
// Optional feature: define RELU_EN to clamp negative results to +0.

module sm_window_accumulator #(
  parameter int DATA_WIDTH = 17,
  parameter int NUM_TERMS  = 9,
  parameter int ACC_WIDTH  = 21,
  localparam int IDX_WIDTH =
    (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] product_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] sum_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_WIDTH-1:0]  term_idx
);

  localparam int PAD = ACC_WIDTH - DATA_WIDTH + 1;

  localparam logic [ACC_WIDTH-1:0] MAG_MAX =
    {{PAD{1'b0}}, {(DATA_WIDTH-1){1'b1}}};

  localparam logic [IDX_WIDTH-1:0] LAST_IDX =
    IDX_WIDTH'(NUM_TERMS - 1);

  typedef enum logic {
    ST_ACCUM,
    ST_LAST
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [IDX_WIDTH-1:0]  idx_q;
  logic [IDX_WIDTH-1:0]  idx_d;
  logic [ACC_WIDTH-1:0]  acc_q;
  logic [ACC_WIDTH-1:0]  acc_d;
  logic [DATA_WIDTH-1:0] sum_q;
  logic [DATA_WIDTH-1:0] sum_d;
  logic                  valid_q;
  logic                  valid_d;

  logic                  in_fire;
  logic [ACC_WIDTH-1:0]  mag_ext;
  logic [ACC_WIDTH-1:0]  term;
  logic [ACC_WIDTH-1:0]  total;
  logic [ACC_WIDTH-1:0]  abs_v;
  logic                  neg;
  logic                  sat;
  logic [DATA_WIDTH-1:0] result;

  assign in_ready  = !rst && (!valid_q || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign sum_out   = sum_q;
  assign out_valid = valid_q;
  assign term_idx  = idx_q;

  // Negative zero negates to zero, so it needs no special case.
  assign mag_ext = {{PAD{1'b0}}, product_in[DATA_WIDTH-2:0]};
  assign term    = product_in[DATA_WIDTH-1] ? (~mag_ext + 1'b1)
                                            : mag_ext;

  // Term 0 starts a fresh window regardless of any stale accumulator.
  assign total = ((idx_q == '0) ? '0 : acc_q) + term;
  assign neg   = total[ACC_WIDTH-1];
  assign abs_v = neg ? (~total + 1'b1) : total;
  assign sat   = abs_v > MAG_MAX;

  always_comb begin
    result = '0;
`ifdef RELU_EN
    if (!neg) begin
      result[DATA_WIDTH-2:0] = sat ? MAG_MAX[DATA_WIDTH-2:0]
                                   : abs_v[DATA_WIDTH-2:0];
    end
`else
    result[DATA_WIDTH-1]   = neg;
    result[DATA_WIDTH-2:0] = sat ? MAG_MAX[DATA_WIDTH-2:0]
                                 : abs_v[DATA_WIDTH-2:0];
`endif
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    valid_d = valid_q && !out_ready;
    if (in_fire) begin
      unique case (state_q)
        ST_LAST: begin
          // A consume in this same cycle is overridden by the new result.
          sum_d   = result;
          valid_d = 1'b1;
          idx_d   = '0;
          acc_d   = '0;
          state_d = ST_ACCUM;
        end
        default: begin
          acc_d   = total;
          idx_d   = idx_q + 1'b1;
          state_d = (idx_q + 1'b1 == LAST_IDX) ? ST_LAST : ST_ACCUM;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      idx_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_sm_window_accumulator.sv
// Randomized bench for sm_window_accumulator against an
// integer reference model with an expected-result queue.

module tb_sm_window_accumulator;

  localparam int DW   = 17;
  localparam int NT   = 9;
  localparam int AW   = 21;
  localparam int MAXM = (1 << (DW - 1)) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] product_in;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] sum_out;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    term_idx;

  sm_window_accumulator #(
    .DATA_WIDTH(DW),
    .NUM_TERMS (NT),
    .ACC_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .product_in(product_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_out   (sum_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .term_idx  (term_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int acc_m    = 0;
  int cnt_m    = 0;
  int n_win    = 0;
  int n_out    = 0;
  int exp_q[$];
  bit in_fire;
  bit out_fire;
  bit rand_ready = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int to_int(input logic [DW-1:0] p);
    int v;
    v = int'(p[DW-2:0]);
    return p[DW-1] ? -v : v;
  endfunction

  function automatic int expect_of(input int s);
    int m;
    m = (s < 0) ? -s : s;
    if (m > MAXM) m = MAXM;
`ifdef RELU_EN
    if (s < 0) return 0;
    return m;
`else
    return (s < 0) ? ((1 << (DW - 1)) + m) : m;
`endif
  endfunction

  // One clock: evaluate handshakes mid-cycle, update model,
  // then return 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    if (rst) begin
      acc_m = 0;
      cnt_m = 0;
      exp_q.delete();
    end else begin
      check("term_idx", 32'(term_idx), cnt_m);
      if (out_fire) begin
        n_out++;
        if (exp_q.size() == 0) check("out_pending", exp_q.size(), 1);
        else check("window_result", 32'(sum_out), exp_q.pop_front());
      end
      if (in_fire) begin
        acc_m += to_int(product_in);
        cnt_m++;
        if (cnt_m == NT) begin
          exp_q.push_back(expect_of(acc_m));
          acc_m = 0;
          cnt_m = 0;
          n_win++;
        end
      end
    end
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [DW-1:0] p);
    int waited;
    waited     = 0;
    product_in = p;
    in_valid   = 1'b1;
    do begin
      tick();
      waited++;
    end while (!in_fire && waited < 100);
    if (!in_fire) check("send_timeout", waited, 0);
  endtask

  task automatic send_n(input logic [DW-1:0] p, input int n);
    for (int i = 0; i < n; i++) send(p);
  endtask

  task automatic expect_window(input string tag,
                               input logic [DW-1:0] v);
    check(tag, 32'(sum_out), 32'(v));
    check({tag, "_valid"}, 32'(out_valid), 1);
    check({tag, "_idx"}, 32'(term_idx), 0);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    rst        = 1'b1;
    product_in = '0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_sum", 32'(sum_out), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_idx", 32'(term_idx), 0);
    rst = 1'b0;
    tick();

    send_n(17'h00100, 9);
    expect_window("w_plain", 17'h00900);
    drain();

    send_n(17'h01000, 5);
    send_n(17'h10800, 4);
    expect_window("w_mixed", 17'h03000);
    drain();

    send_n(17'h11000, 9);
`ifdef RELU_EN
    expect_window("w_neg", 17'h00000);
`else
    expect_window("w_neg", 17'h19000);
`endif
    drain();

    send_n(17'h0FFFF, 9);
    expect_window("w_sat_pos", 17'h0FFFF);
    drain();

    send_n(17'h1FFFF, 9);
`ifdef RELU_EN
    expect_window("w_sat_neg", 17'h00000);
`else
    expect_window("w_sat_neg", 17'h1FFFF);
`endif
    drain();

    out_ready = 1'b0;
    send_n(17'h00010, 9);
    product_in = 17'h00005;
    in_valid   = 1'b1;
    expect_window("w_bp", 17'h00090);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_in_ready", 32'(in_ready), 0);
      check("bp_sum", 32'(sum_out), 32'h90);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release", 32'(in_ready), 1);
    send_n(17'h00005, 9);
    expect_window("w_after_bp", 17'h0002D);
    drain();

    send_n(17'h00100, 4);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("mid_rst_in_ready", 32'(in_ready), 0);
    tick();
    rst = 1'b0;
    check("mid_rst_idx", 32'(term_idx), 0);
    check("mid_rst_valid", 32'(out_valid), 0);
    send_n(17'h00001, 9);
    expect_window("w_post_rst", 17'h00009);
    drain();

    for (int i = 0; i < 9; i++)
      send((i % 2 == 0) ? 17'h10000 : 17'h00003);
    expect_window("w_negzero", 17'h0000C);
    drain();

    for (int w = 0; w < 40; w++) begin
      rand_ready = (w >= 20);
      for (int t = 0; t < NT; t++) begin
        logic [DW-1:0] p;
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
        p[DW-1]   = 1'($urandom_range(0, 1));
        p[DW-2:0] = ($urandom_range(0, 3) == 0)
                    ? 16'($urandom_range(0, 16))
                    : 16'($urandom_range(0, MAXM));
        send(p);
      end
    end
    rand_ready = 1'b0;
    drain();
    check("queue_empty", exp_q.size(), 0);
    check("window_count", n_out, n_win);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
